// File: rtl/control_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes
// and the select-field values seen by the extender, ALU decoder and datapath muxes.
package control_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALRADR, S_JALRJMP,
      S_LUI, S_AUIPC, S_TRAP
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [1:0] IMM_I  = 2'b00;
   localparam logic [1:0] IMM_S  = 2'b01;
   localparam logic [1:0] IMM_B  = 2'b10;
   localparam logic [1:0] IMM_UJ = 2'b11;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
interface multicycle_controller_if #(parameter int CNT_W = 32);
   logic [6:0]       Op;
   logic [2:0]       Funct3;
   logic             Zero;
   logic             MemReady;
   logic             PCWrite;
   logic             AdrSrc;
   logic             MemWrite;
   logic             IRWrite;
   logic             RegWrite;
   logic [1:0]       ResultSrc;
   logic [1:0]       ALUSrcA;
   logic [1:0]       ALUSrcB;
   logic [1:0]       ALUOp;
   logic [1:0]       ImmSrc;
   logic             Illegal;
   logic [CNT_W-1:0] InstRet;

   modport master (
      input  Op, Funct3, Zero, MemReady,
      output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Illegal, InstRet
   );

   modport slave (
      output Op, Funct3, Zero, MemReady,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Illegal, InstRet
   );
endinterface

// File: rtl/imm_src_decoder.sv
// Opcode to immediate-format map; kept standalone so a pipelined decode stage can reuse it.
module imm_src_decoder
   import control_pkg::*;
(
   input  logic [6:0] op,
   output logic [1:0] imm_src
);
   always_comb begin
      imm_src = IMM_I;
      case (op)
         OP_STORE:                imm_src = IMM_S;
         OP_BRANCH:               imm_src = IMM_B;
         OP_LUI, OP_AUIPC, OP_JAL: imm_src = IMM_UJ;
         default:                 imm_src = IMM_I;
      endcase
   end
endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute,
// stalls on MemReady, traps unknown opcodes and counts retired instructions.
module multicycle_controller
   import control_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   multicycle_controller_if.master  bus
);
   state_t           state_q, state_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] instret_q, instret_d;

   logic       taken, retire;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write;
   logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

   imm_src_decoder u_imm (.op(bus.Op), .imm_src(bus.ImmSrc));

   // Only beq/bne are supported; any other Funct3 falls through untaken.
   assign taken = (bus.Funct3 == F3_BEQ &&  bus.Zero) ||
                  (bus.Funct3 == F3_BNE && !bus.Zero);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    if (bus.MemReady) state_d = S_DECODE;
         S_DECODE: begin
            case (bus.Op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_ITYPE:          state_d = S_EXECI;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALRADR;
               OP_LUI:            state_d = S_LUI;
               OP_AUIPC:          state_d = S_AUIPC;
               default:           state_d = S_TRAP;
            endcase
         end
         S_MEMADR:   state_d = (bus.Op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (bus.MemReady) state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: if (bus.MemReady) state_d = S_FETCH;
         S_EXECR, S_EXECI, S_JAL, S_JALRJMP, S_LUI, S_AUIPC:
                     state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BRANCH:   state_d = S_FETCH;
         S_JALRADR:  state_d = S_JALRJMP;
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_TRAP;
      endcase
   end

   always_comb begin
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = RES_ALUOUT;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      alu_op     = ALUOP_ADD;
      case (state_q)
         S_FETCH: begin
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURESULT;
            pc_write   = bus.MemReady;
            ir_write   = bus.MemReady;
         end
         S_DECODE:   begin alu_src_a = SRCA_OLDPC; alu_src_b = SRCB_IMM; end
         S_MEMADR:   begin alu_src_a = SRCA_RS1;   alu_src_b = SRCB_IMM; end
         S_MEMREAD:  adr_src = 1'b1;
         S_MEMWB:    begin result_src = RES_DATA; reg_write = 1'b1; end
         S_MEMWRITE: begin adr_src = 1'b1; mem_write = 1'b1; end
         S_EXECR:    begin alu_src_a = SRCA_RS1; alu_op = ALUOP_FUNCT; end
         S_EXECI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB:    reg_write = 1'b1;
         S_BRANCH: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALUOP_SUB;
            pc_write  = taken;
         end
         // Both jump flavours write OldPC+4 as the link value, PC takes the precomputed target.
         S_JAL, S_JALRJMP: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
            pc_write  = 1'b1;
         end
         S_JALRADR:  begin alu_src_a = SRCA_RS1;   alu_src_b = SRCB_IMM; end
         S_LUI:      begin alu_src_a = SRCA_ZERO;  alu_src_b = SRCB_IMM; end
         S_AUIPC:    begin alu_src_a = SRCA_OLDPC; alu_src_b = SRCB_IMM; end
         default: ;
      endcase
      if (rst) begin
         pc_write  = 1'b0;
         ir_write  = 1'b0;
         reg_write = 1'b0;
         mem_write = 1'b0;
      end
   end

   assign retire = !rst && (state_q == S_MEMWB || state_q == S_ALUWB ||
                            state_q == S_BRANCH ||
                            (state_q == S_MEMWRITE && bus.MemReady));

   always_comb begin
      instret_d = instret_q;
      if (retire) instret_d = instret_q + CNT_W'(1);
      illegal_d = illegal_q | (state_d == S_TRAP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         instret_q <= instret_d;
      end
   end

   assign bus.PCWrite   = pc_write;
   assign bus.AdrSrc    = adr_src;
   assign bus.MemWrite  = mem_write;
   assign bus.IRWrite   = ir_write;
   assign bus.RegWrite  = reg_write;
   assign bus.ResultSrc = result_src;
   assign bus.ALUSrcA   = alu_src_a;
   assign bus.ALUSrcB   = alu_src_b;
   assign bus.ALUOp     = alu_op;
   assign bus.Illegal   = illegal_q;
   assign bus.InstRet   = instret_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: each driven cycle pushes the expected control word and
// retire count; a negedge monitor pops and compares against the DUT.
module tb_multicycle_controller;
   localparam int CW = 4;

   typedef enum {T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
                 T_EXECR, T_EXECI, T_ALUWB, T_BRANCH, T_JAL, T_JALRADR,
                 T_JALRJMP, T_LUI, T_AUIPC, T_TRAP} tst_t;

   typedef struct {
      logic [15:0]   w;
      logic [CW-1:0] ret;
      string         tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb_q[$];
   exp_t mon_e;
   logic [CW-1:0] exp_ret = '0;

   multicycle_controller_if #(.CNT_W(CW)) bus();

   multicycle_controller #(.CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] imm_of(logic [6:0] op);
      case (op)
         7'b0000011, 7'b0010011, 7'b1100111: return 2'b00;
         7'b0100011:                         return 2'b01;
         7'b1100011:                         return 2'b10;
         7'b0110111, 7'b0010111, 7'b1101111: return 2'b11;
         default:                            return 2'b00;
      endcase
   endfunction

   // Control word expected from the state table; field order matches obs_word.
   function automatic logic [15:0] exp_word(tst_t s, logic [6:0] op, logic [2:0] f3,
                                            logic z, logic mr, logic r);
      logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0;
      logic [1:0] rs = 0, sa = 0, sb = 0, ao = 0;
      case (s)
         T_FETCH:    begin sb = 2'b10; rs = 2'b10; pcw = mr; irw = mr; end
         T_DECODE:   begin sa = 2'b01; sb = 2'b01; end
         T_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
         T_MEMREAD:  adr = 1;
         T_MEMWB:    begin rs = 2'b01; rw = 1; end
         T_MEMWRITE: begin adr = 1; mw = 1; end
         T_EXECR:    begin sa = 2'b10; ao = 2'b10; end
         T_EXECI:    begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
         T_ALUWB:    rw = 1;
         T_BRANCH:   begin sa = 2'b10; ao = 2'b01;
                           pcw = (f3 == 3'b000 && z) || (f3 == 3'b001 && !z); end
         T_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
         T_JALRADR:  begin sa = 2'b10; sb = 2'b01; end
         T_JALRJMP:  begin sa = 2'b01; sb = 2'b10; pcw = 1; end
         T_LUI:      begin sa = 2'b11; sb = 2'b01; end
         T_AUIPC:    begin sa = 2'b01; sb = 2'b01; end
         T_TRAP:     ill = 1;
         default: ;
      endcase
      if (r) begin pcw = 0; irw = 0; rw = 0; mw = 0; end
      return {pcw, adr, mw, irw, rw, rs, sa, sb, ao, imm_of(op), ill};
   endfunction

   wire [15:0] obs_word = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite,
                           bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB,
                           bus.ALUOp, bus.ImmSrc, bus.Illegal};

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         chk({mon_e.tag, "_ctl"}, 32'(obs_word), 32'(mon_e.w));
         chk({mon_e.tag, "_instret"}, 32'(bus.InstRet), 32'(mon_e.ret));
      end
   end

   // One clock of stimulus: s is the state the DUT should be in during this cycle.
   task automatic cyc(tst_t s, logic mr = 1'b1, logic z = 1'b0, logic r = 1'b0);
      exp_t e;
      bus.MemReady = mr;
      bus.Zero     = z;
      rst          = r;
      e.w   = exp_word(s, bus.Op, bus.Funct3, z, mr, r);
      e.ret = exp_ret;
      e.tag = s.name();
      sb_q.push_back(e);
      if (r) exp_ret = '0;
      else if (s == T_MEMWB || s == T_ALUWB || s == T_BRANCH || (s == T_MEMWRITE && mr))
         exp_ret = exp_ret + 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(logic [6:0] op, logic [2:0] f3);
      bus.Op     = op;
      bus.Funct3 = f3;
   endtask

   task automatic branch(logic [2:0] f3, logic z);
      set_instr(7'b1100011, f3);
      cyc(T_FETCH); cyc(T_DECODE, 1'b0); cyc(T_BRANCH, 1'b1, z);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not finish, checks=%0d", n_checks);
      $fatal(1, "timeout");
   end

   initial begin
      bus.Op = 7'b0010011; bus.Funct3 = 3'b000; bus.Zero = 1'b0; bus.MemReady = 1'b0;
      @(posedge clk);
      #1;
      cyc(T_FETCH, 1'b1, 1'b0, 1'b1);

      // addi
      set_instr(7'b0010011, 3'b000);
      cyc(T_FETCH); cyc(T_DECODE); cyc(T_EXECI); cyc(T_ALUWB);

      // sw with three wait cycles in MEMWRITE
      set_instr(7'b0100011, 3'b010);
      cyc(T_FETCH); cyc(T_DECODE); cyc(T_MEMADR, 1'b0);
      cyc(T_MEMWRITE, 1'b0); cyc(T_MEMWRITE, 1'b0); cyc(T_MEMWRITE, 1'b0);
      cyc(T_MEMWRITE, 1'b1);

      // lw with a fetch stall and a read stall
      set_instr(7'b0000011, 3'b010);
      cyc(T_FETCH, 1'b0); cyc(T_FETCH); cyc(T_DECODE); cyc(T_MEMADR);
      cyc(T_MEMREAD, 1'b0); cyc(T_MEMREAD); cyc(T_MEMWB, 1'b0);

      branch(3'b000, 1'b1); branch(3'b000, 1'b0);
      branch(3'b001, 1'b1); branch(3'b001, 1'b0);
      branch(3'b100, 1'b1);

      set_instr(7'b1101111, 3'b000);
      cyc(T_FETCH); cyc(T_DECODE); cyc(T_JAL, 1'b0); cyc(T_ALUWB);
      set_instr(7'b1100111, 3'b000);
      cyc(T_FETCH); cyc(T_DECODE); cyc(T_JALRADR); cyc(T_JALRJMP); cyc(T_ALUWB);
      set_instr(7'b0110111, 3'b000);
      cyc(T_FETCH); cyc(T_DECODE); cyc(T_LUI); cyc(T_ALUWB);
      set_instr(7'b0010111, 3'b000);
      cyc(T_FETCH); cyc(T_DECODE); cyc(T_AUIPC); cyc(T_ALUWB);
      set_instr(7'b0110011, 3'b000);
      cyc(T_FETCH); cyc(T_DECODE); cyc(T_EXECR, 1'b0); cyc(T_ALUWB);

      // reset while in MEMREAD abandons the load
      set_instr(7'b0000011, 3'b010);
      cyc(T_FETCH); cyc(T_DECODE); cyc(T_MEMADR); cyc(T_MEMREAD, 1'b0, 1'b0, 1'b1);
      set_instr(7'b0010011, 3'b000);
      cyc(T_FETCH); cyc(T_DECODE); cyc(T_EXECI); cyc(T_ALUWB);

      // unsupported opcode traps until reset
      set_instr(7'b1111111, 3'b000);
      cyc(T_FETCH); cyc(T_DECODE);
      for (int i = 0; i < 20; i++) cyc(T_TRAP, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cyc(T_TRAP, 1'b1, 1'b0, 1'b1);
      set_instr(7'b0010011, 3'b000);
      cyc(T_FETCH); cyc(T_DECODE); cyc(T_EXECI); cyc(T_ALUWB);

      // 16 retirements from reset wrap the 4-bit counter
      cyc(T_FETCH, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) branch(3'(i % 2), 1'(i / 3));
      set_instr(7'b0010011, 3'b000);
      cyc(T_FETCH, 1'b0);

      repeat (2) @(negedge clk);
      chk("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
